// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, ALU op codes and forwarding-select encodings
package riscv_pkg;
   localparam int XLEN_DEF = 32;
   localparam int REGW_DEF = 5;
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;
   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2
   } fwd_sel_e;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks the youngest in-flight producer of rs, falling back to the register file
module fwd_mux
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int REGW = REGW_DEF
) (
   input  logic [REGW-1:0] rs,
   input  logic [XLEN-1:0] rf_data,
   input  logic [REGW-1:0] mem_rd,
   input  logic            mem_reg_write,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [REGW-1:0] wb_rd,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_result,
   output logic [XLEN-1:0] data,
   output fwd_sel_e        sel
);
   logic mem_hit, wb_hit;
   assign mem_hit = mem_reg_write && mem_rd != '0 && mem_rd == rs;
   assign wb_hit  = wb_reg_write && wb_rd != '0 && wb_rd == rs;
   always_comb begin
      sel  = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
      data = mem_hit ? mem_alu_result : wb_hit ? wb_result : rf_data;
   end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush and operand forwarding
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int REGW = REGW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_rd1,
   input  logic [XLEN-1:0] id_rd2,
   input  logic [XLEN-1:0] id_imm,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [2:0]      id_alu_control,
   input  logic            id_alu_src,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            flush,
   input  logic [REGW-1:0] mem_rd,
   input  logic            mem_reg_write,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [REGW-1:0] wb_rd,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_result,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_src_a,
   output logic [XLEN-1:0] ex_src_b,
   output logic [2:0]      ex_alu_control,
   output logic [XLEN-1:0] ex_write_data,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic [1:0]      ex_fwd_sel_a,
   output logic [1:0]      ex_fwd_sel_b
);
   logic [REGW-1:0] ex_rs1, ex_rs2;
   logic [XLEN-1:0] rd1_q, rd2_q, imm_q, fwd_a, fwd_b;
   logic            alu_src_q, reg_write_q, mem_read_q, haz;

   assign ex_reg_write = ex_valid & reg_write_q;
   assign ex_mem_read  = ex_valid & mem_read_q;
   assign haz = id_valid & ex_mem_read & (ex_rd != '0) & ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));
   assign id_ready = ~haz;

   // flush and load-use both leave a bubble; fields other than the enables are kept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid       <= 1'b0;
         ex_rs1         <= '0;
         ex_rs2         <= '0;
         ex_rd          <= '0;
         rd1_q          <= '0;
         rd2_q          <= '0;
         imm_q          <= '0;
         ex_alu_control <= ALU_ADD;
         alu_src_q      <= 1'b0;
         reg_write_q    <= 1'b0;
         mem_read_q     <= 1'b0;
      end else if (flush || haz) begin
         ex_valid    <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         ex_valid       <= id_valid;
         ex_rs1         <= id_rs1;
         ex_rs2         <= id_rs2;
         ex_rd          <= id_rd;
         rd1_q          <= id_rd1;
         rd2_q          <= id_rd2;
         imm_q          <= id_imm;
         ex_alu_control <= id_alu_control;
         alu_src_q      <= id_alu_src;
         reg_write_q    <= id_reg_write;
         mem_read_q     <= id_mem_read;
      end
   end

   fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
      .rs(ex_rs1), .rf_data(rd1_q),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_result(mem_alu_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .data(fwd_a), .sel(ex_fwd_sel_a)
   );

   fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
      .rs(ex_rs2), .rf_data(rd2_q),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_result(mem_alu_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .data(fwd_b), .sel(ex_fwd_sel_b)
   );

   assign ex_src_a      = fwd_a;
   assign ex_src_b      = alu_src_q ? imm_q : fwd_b;
   assign ex_write_data = fwd_b;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus random traffic against a behavioural EX-slot model
module tb_id_ex_stage;
   logic        clk = 1'b0, reset;
   logic        id_valid, id_ready, id_alu_src, id_reg_write, id_mem_read, flush;
   logic [31:0] id_rd1, id_rd2, id_imm, mem_alu_result, wb_result;
   logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
   logic [2:0]  id_alu_control;
   logic        mem_reg_write, wb_reg_write;
   logic        ex_valid, ex_reg_write, ex_mem_read;
   logic [31:0] ex_src_a, ex_src_b, ex_write_data;
   logic [2:0]  ex_alu_control;
   logic [4:0]  ex_rd;
   logic [1:0]  ex_fwd_sel_a, ex_fwd_sel_b;
   int checks = 0, errors = 0;
   logic last_haz = 1'b0;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rd1, rd2, imm;
      logic [2:0]  alu;
      logic        src, rw, mr;
   } ex_t;
   ex_t m;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_result(mem_alu_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .ex_valid(ex_valid), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
      .ex_alu_control(ex_alu_control), .ex_write_data(ex_write_data), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_fwd_sel_a(ex_fwd_sel_a), .ex_fwd_sel_b(ex_fwd_sel_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_haz();
      return id_valid && m.valid && m.mr && m.rd != 0 && (id_rs1 == m.rd || id_rs2 == m.rd);
   endfunction

   // value a source register resolves to: newest writer in flight, never x0
   function automatic logic [31:0] ref_val(input logic [4:0] rs, input logic [31:0] rf);
      if (rs != 0 && mem_reg_write && mem_rd == rs) return mem_alu_result;
      if (rs != 0 && wb_reg_write && wb_rd == rs) return wb_result;
      return rf;
   endfunction

   function automatic logic [1:0] ref_sel(input logic [4:0] rs);
      if (rs != 0 && mem_reg_write && mem_rd == rs) return 2'd2;
      if (rs != 0 && wb_reg_write && wb_rd == rs) return 2'd1;
      return 2'd0;
   endfunction

   task automatic check_all();
      chk("ex_valid", 32'(ex_valid), 32'(m.valid));
      chk("id_ready", 32'(id_ready), 32'(!model_haz()));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m.valid & m.rw));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(m.valid & m.mr));
      if (m.valid) begin
         chk("ex_src_a", ex_src_a, ref_val(m.rs1, m.rd1));
         chk("ex_src_b", ex_src_b, m.src ? m.imm : ref_val(m.rs2, m.rd2));
         chk("ex_write_data", ex_write_data, ref_val(m.rs2, m.rd2));
         chk("ex_rd", 32'(ex_rd), 32'(m.rd));
         chk("ex_alu_control", 32'(ex_alu_control), 32'(m.alu));
         chk("fwd_sel_a", 32'(ex_fwd_sel_a), 32'(ref_sel(m.rs1)));
         chk("fwd_sel_b", 32'(ex_fwd_sel_b), 32'(ref_sel(m.rs2)));
      end
   endtask

   task automatic cyc();
      ex_t n = m;
      last_haz = model_haz();
      if (reset) n = '0;
      else if (flush || last_haz) begin
         n.valid = 1'b0; n.rw = 1'b0; n.mr = 1'b0;
      end else begin
         n = '{id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_alu_control,
               id_alu_src, id_reg_write, id_mem_read};
      end
      @(posedge clk);
      m = n;
      #2;
   endtask

   task automatic set_id(input logic v, input logic [2:0] alu, input logic [4:0] rd, rs1, rs2,
                         input logic [31:0] rd1, rd2, imm, input logic src, rw, mr);
      id_valid = v; id_alu_control = alu; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alu_src = src; id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic clr_fwd();
      mem_rd = 0; mem_reg_write = 0; mem_alu_result = 0;
      wb_rd = 0; wb_reg_write = 0; wb_result = 0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; m = '0;
      set_id(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clr_fwd();
      #2;
      check_all();
      chk("rst_src_a", ex_src_a, 32'h0);
      chk("rst_src_b", ex_src_b, 32'h0);
      chk("rst_wdata", ex_write_data, 32'h0);
      chk("rst_alu", 32'(ex_alu_control), 32'h0);
      cyc();
      reset = 1'b0;
      // plain ADD, no hazards
      set_id(1, 3'b000, 5, 1, 2, 7, 3, 0, 0, 1, 0);
      cyc();
      id_valid = 0;
      #1 check_all();
      chk("add_a", ex_src_a, 32'd7);
      chk("add_b", ex_src_b, 32'd3);
      chk("add_valid", 32'(ex_valid), 32'd1);
      // mem beats wb on the same register, then wb alone
      mem_rd = 1; mem_reg_write = 1; mem_alu_result = 32'h100;
      wb_rd = 1; wb_reg_write = 1; wb_result = 32'h200;
      #1 check_all();
      chk("fwd_mem", ex_src_a, 32'h100);
      mem_reg_write = 0;
      #1 check_all();
      chk("fwd_wb", ex_src_a, 32'h200);
      // x0 must never pick up a forwarded value
      clr_fwd();
      set_id(1, 3'b000, 3, 0, 0, 0, 0, 0, 0, 1, 0);
      mem_rd = 0; mem_reg_write = 1; mem_alu_result = 32'hDEAD;
      cyc();
      id_valid = 0;
      #1 check_all();
      chk("x0_nofwd", ex_src_a, 32'h0);
      clr_fwd();
      // load-use: exactly one bubble, SUB appears once afterwards
      set_id(1, 3'b000, 6, 0, 0, 0, 0, 0, 1, 1, 1);
      cyc();
      set_id(1, 3'b001, 7, 1, 6, 11, 22, 0, 0, 1, 0);
      #1 check_all();
      chk("lu_stall", 32'(id_ready), 32'd0);
      cyc();
      #1 check_all();
      chk("lu_bubble_v", 32'(ex_valid), 32'd0);
      chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
      chk("lu_ready_back", 32'(id_ready), 32'd1);
      cyc();
      id_valid = 0;
      #1 check_all();
      chk("lu_sub_v", 32'(ex_valid), 32'd1);
      chk("lu_sub_op", 32'(ex_alu_control), 32'b001);
      cyc();
      #1 check_all();
      chk("lu_no_dup", 32'(ex_valid), 32'd0);
      // flush kills SLT; without flush it arrives with the immediate on B
      set_id(1, 3'b101, 8, 1, 0, 5, 9, 32'hFFFFFFFC, 1, 1, 0);
      flush = 1;
      cyc();
      flush = 0;
      #1 check_all();
      chk("flush_v", 32'(ex_valid), 32'd0);
      chk("flush_rw", 32'(ex_reg_write), 32'd0);
      cyc();
      id_valid = 0;
      #1 check_all();
      chk("slt_b", ex_src_b, 32'hFFFFFFFC);
      chk("slt_op", 32'(ex_alu_control), 32'b101);
      // async reset in the middle of a stall
      set_id(1, 3'b000, 6, 0, 0, 0, 0, 0, 1, 1, 1);
      cyc();
      set_id(1, 3'b001, 7, 6, 2, 1, 2, 0, 0, 1, 0);
      #1 chk("pre_rst_stall", 32'(id_ready), 32'd0);
      reset = 1;
      m = '0;
      #1 check_all();
      chk("mid_rst_valid", 32'(ex_valid), 32'd0);
      chk("mid_rst_ready", 32'(id_ready), 32'd1);
      chk("mid_rst_alu", 32'(ex_alu_control), 32'h0);
      cyc();
      reset = 0;
      // random traffic; decode holds its instruction while stalled
      for (int i = 0; i < 600; i++) begin
         if (!last_haz)
            set_id($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
         flush = $urandom_range(0, 9) == 0;
         mem_rd = 5'($urandom_range(0, 7)); mem_reg_write = $urandom_range(0, 1) == 1;
         mem_alu_result = $urandom;
         wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = $urandom_range(0, 1) == 1;
         wb_result = $urandom;
         #1 check_all();
         cyc();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
